// File: rtl/flag_ctrl_if.sv
// -----------------------------------------------------------------------------
// flag_ctrl_if
// Bundles the pipeline-side signals of the flag scheduler / condition unit.
//   stall_i, flush_i             pipeline freeze / wrong-path kill
//   ex_valid_i, ex_mask_i,
//   ex_flags_i                   EX-stage flag write (mask and values, [3]=C [2]=Z [1]=V [0]=S)
//   cond_valid_i, cond_i         ID-stage conditional branch and its condition code
//   save_i, restore_i            interrupt entry / return request pulses
//   flags_o                      architectural flags (registered)
//   fwd_flags_o                  architectural flags overlaid by WB slot, then MEM slot
//   cond_taken_o                 condition result from fwd_flags_o
//   flag_stall_o                 ID must stall for a flag produced in EX
//   busy_o                       save/restore drain in progress
//   saved_flags_o                copy of the flags taken at interrupt entry
// master: the pipeline driving requests; slave: flag_ctrl.
// -----------------------------------------------------------------------------
interface flag_ctrl_if;
    logic       stall_i;
    logic       flush_i;
    logic       ex_valid_i;
    logic [3:0] ex_mask_i;
    logic [3:0] ex_flags_i;
    logic       cond_valid_i;
    logic [2:0] cond_i;
    logic       save_i;
    logic       restore_i;
    logic [3:0] flags_o;
    logic [3:0] fwd_flags_o;
    logic       cond_taken_o;
    logic       flag_stall_o;
    logic       busy_o;
    logic [3:0] saved_flags_o;

    modport master (
        output stall_i, flush_i, ex_valid_i, ex_mask_i, ex_flags_i,
               cond_valid_i, cond_i, save_i, restore_i,
        input  flags_o, fwd_flags_o, cond_taken_o, flag_stall_o,
               busy_o, saved_flags_o
    );

    modport slave (
        input  stall_i, flush_i, ex_valid_i, ex_mask_i, ex_flags_i,
               cond_valid_i, cond_i, save_i, restore_i,
        output flags_o, fwd_flags_o, cond_taken_o, flag_stall_o,
               busy_o, saved_flags_o
    );
endinterface

// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
// Flag-update scheduler and condition unit for the 16-bit 5-stage pipeline.
// EX flag writes travel through MEM and WB shadow slots and commit to the
// architectural C/Z/V/S flags at WB. Pending slot values are forwarded to the
// branch-condition evaluator in ID; a flag still being produced in EX causes
// a stall instead. Interrupt entry/return save and restore the flags once the
// shadow slots have drained.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   flag_ctrl_if.slave (pipeline requests and all flag outputs)
// Flag bit order: [3]=C [2]=Z [1]=V [0]=S.
// -----------------------------------------------------------------------------
module flag_ctrl (
    input  logic          clk,
    input  logic          rst,
    flag_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SAVE_DRAIN = 2'd1,
        ST_SAVED      = 2'd2,
        ST_REST_DRAIN = 2'd3
    } state_t;

    // Shadow slots
    logic       r_mem_valid;
    logic [3:0] r_mem_mask;
    logic [3:0] r_mem_flags;
    logic       r_wb_valid;
    logic [3:0] r_wb_mask;
    logic [3:0] r_wb_flags;

    // Architectural and saved flags
    logic [3:0] r_flags;
    logic [3:0] r_saved;

    // FSM
    state_t     r_state;
    state_t     w_state_next;
    logic       w_busy;
    logic       w_save_done;
    logic       w_rest_done;

    logic       w_slots_empty;
    logic [3:0] w_commit_flags;
    logic [3:0] w_fwd_flags;
    logic [3:0] w_need_mask;
    logic       w_cond_taken;

    assign w_slots_empty = ~r_mem_valid & ~r_wb_valid;

    // Per-bit commit value and forward overlay. MEM is newer than WB, so it
    // wins when both slots write the same field.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_flag_bit
            assign w_commit_flags[gi] = (r_wb_valid & r_wb_mask[gi]) ? r_wb_flags[gi]
                                                                     : r_flags[gi];
            assign w_fwd_flags[gi]    = (r_mem_valid & r_mem_mask[gi]) ? r_mem_flags[gi]
                                                                       : w_commit_flags[gi];
        end
    endgenerate

    // Condition evaluation on forwarded flags, plus the set of fields each
    // condition depends on (used for the EX hazard check).
    always_comb begin
        w_need_mask  = 4'b0000;
        w_cond_taken = 1'b1;
        case (bus.cond_i)
            3'b000: begin w_need_mask = 4'b0000; w_cond_taken = 1'b1;                              end
            3'b001: begin w_need_mask = 4'b0100; w_cond_taken = w_fwd_flags[2];                    end
            3'b010: begin w_need_mask = 4'b0100; w_cond_taken = ~w_fwd_flags[2];                   end
            3'b011: begin w_need_mask = 4'b1000; w_cond_taken = w_fwd_flags[3];                    end
            3'b100: begin w_need_mask = 4'b1000; w_cond_taken = ~w_fwd_flags[3];                   end
            3'b101: begin w_need_mask = 4'b0001; w_cond_taken = w_fwd_flags[0];                    end
            3'b110: begin w_need_mask = 4'b0010; w_cond_taken = w_fwd_flags[1];                    end
            default: begin w_need_mask = 4'b0011; w_cond_taken = w_fwd_flags[0] ^ w_fwd_flags[1]; end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and outputs. Drain completion looks only at the slot
    // state present at the edge, so empty slots finish with no extra cycle.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_save_done  = 1'b0;
        w_rest_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.save_i) begin
                    w_state_next = ST_SAVE_DRAIN;
                end
            end
            ST_SAVE_DRAIN: begin
                w_busy = 1'b1;
                if (w_slots_empty) begin
                    w_save_done  = 1'b1;
                    w_state_next = ST_SAVED;
                end
            end
            ST_SAVED: begin
                if (bus.restore_i) begin
                    w_state_next = ST_REST_DRAIN;
                end
            end
            ST_REST_DRAIN: begin
                w_busy = 1'b1;
                if (w_slots_empty) begin
                    w_rest_done  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shadow slot pipeline. A stall freezes both slots, but a flush still
    // kills the MEM entry; the WB entry is past the point of no return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_mask  <= 4'b0000;
            r_mem_flags <= 4'b0000;
            r_wb_valid  <= 1'b0;
            r_wb_mask   <= 4'b0000;
            r_wb_flags  <= 4'b0000;
        end else if (!bus.stall_i) begin
            r_wb_valid  <= r_mem_valid & ~bus.flush_i;
            r_wb_mask   <= r_mem_mask;
            r_wb_flags  <= r_mem_flags;
            r_mem_valid <= bus.ex_valid_i & ~bus.flush_i;
            r_mem_mask  <= bus.ex_mask_i;
            r_mem_flags <= bus.ex_flags_i;
        end else if (bus.flush_i) begin
            r_mem_valid <= 1'b0;
        end
    end

    // Architectural flags. The restore write is ordered ahead of the commit;
    // in practice they never coincide since restore waits for empty slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (w_rest_done) begin
            r_flags <= r_saved;
        end else if (!bus.stall_i) begin
            r_flags <= w_commit_flags;
        end
    end

    // Saved copy taken from the architectural flags at drain completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_saved <= 4'b0000;
        end else if (w_save_done) begin
            r_saved <= r_flags;
        end
    end

    assign bus.flags_o       = r_flags;
    assign bus.fwd_flags_o   = w_fwd_flags;
    assign bus.cond_taken_o  = w_cond_taken;
    assign bus.flag_stall_o  = bus.cond_valid_i & bus.ex_valid_i & ~bus.flush_i &
                               (|(bus.ex_mask_i & w_need_mask));
    assign bus.busy_o        = w_busy;
    assign bus.saved_flags_o = r_saved;

endmodule
